// File: rtl/sap_pkg.sv
// sap_pkg: shared constants and types for the SAP CPU datapath.
//   DATA_W / ADDR_W : default bus and address widths
//   bus_src_t       : which source currently owns the shared bus
//   ctrl_t          : decoder control word, bit order {hlt ... j}
package sap_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_SUM,
    SRC_A,
    SRC_RAM,
    SRC_IR,
    SRC_PC
  } bus_src_t;

  typedef struct packed {
    logic hlt;
    logic mi;
    logic ri;
    logic ro;
    logic io;
    logic ii;
    logic ai;
    logic ao;
    logic sumo;
    logic sub;
    logic bi;
    logic oi;
    logic ce;
    logic co;
    logic j;
  } ctrl_t;

  // Fixed bus priority: sumo > ao > ro > io > co.
  function automatic bus_src_t sel_bus_src(input ctrl_t c);
    if (c.sumo)    return SRC_SUM;
    else if (c.ao) return SRC_A;
    else if (c.ro) return SRC_RAM;
    else if (c.io) return SRC_IR;
    else if (c.co) return SRC_PC;
    else           return SRC_NONE;
  endfunction

endpackage

// File: rtl/sap_ram.sv
// sap_ram: 2^ADDR_W x DATA_W program/data RAM.
//   clk                         : write clock (posedge)
//   prog_mode/prog_we/prog_addr/prog_data : program-load write port
//   dp_we/dp_addr/dp_data       : datapath write port (used when not in prog_mode)
//   raddr/rdata                 : asynchronous read port
module sap_ram #(
  parameter int DATA_W = sap_pkg::DATA_W,
  parameter int ADDR_W = sap_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              prog_mode,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              dp_we,
  input  logic [ADDR_W-1:0] dp_addr,
  input  logic [DATA_W-1:0] dp_data,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  import sap_pkg::*;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  // The program port owns the write side for the whole of prog_mode.
  assign we    = prog_mode ? prog_we   : dp_we;
  assign waddr = prog_mode ? prog_addr : dp_addr;
  assign wdata = prog_mode ? prog_data : dp_data;

  // NOTE: the array has no reset so a loaded program survives a CPU reset and
  // the storage maps onto plain RAM cells rather than resettable flops.
  // NOTE: sequential state is always written with <= so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sap_datapath.sv
// sap_datapath: register/bus datapath of the 8-bit SAP CPU.
//   clk, rst (async, active-low)
//   prog_mode, prog_we, prog_addr, prog_data : program-load port
//   hlt..j      : one-hot-ish decoder control lines, valid from negedge
//   insn        : instruction register
//   cf, zf      : carry / zero flags (updated only on sumo)
//   out_val     : output register
//   pc_dbg      : program counter
//   bus_dbg     : combinational bus value (0 in prog_mode)
//   halted      : sticky halt, cleared only by reset
module sap_datapath #(
  parameter int DATA_W = sap_pkg::DATA_W,
  parameter int ADDR_W = sap_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_mode,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              hlt,
  input  logic              mi,
  input  logic              ri,
  input  logic              ro,
  input  logic              io,
  input  logic              ii,
  input  logic              ai,
  input  logic              ao,
  input  logic              sumo,
  input  logic              sub,
  input  logic              bi,
  input  logic              oi,
  input  logic              ce,
  input  logic              co,
  input  logic              j,
  output logic [DATA_W-1:0] insn,
  output logic              cf,
  output logic              zf,
  output logic [DATA_W-1:0] out_val,
  output logic [ADDR_W-1:0] pc_dbg,
  output logic [DATA_W-1:0] bus_dbg,
  output logic              halted
);
  import sap_pkg::*;

  ctrl_t             ctrl;
  bus_src_t          bus_src;
  logic              active;
  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] a_q, b_q, ir_q, out_q;
  logic [ADDR_W-1:0] mar_q, pc_q;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W:0]   sum;

  assign ctrl = {hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j};

  // Loads happen only outside prog_mode, before halt, and not on the halt edge.
  assign active  = !prog_mode && !halted && !ctrl.hlt;
  assign bus_src = prog_mode ? SRC_NONE : sel_bus_src(ctrl);

  // sub turns the adder into A + ~B + 1; carry out of bit DATA_W is the flag.
  assign sum = {1'b0, a_q} + {1'b0, (ctrl.sub ? ~b_q : b_q)}
             + {{DATA_W{1'b0}}, ctrl.sub};

  // NOTE: bus gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    bus = '0;
    unique case (bus_src)
      SRC_SUM:  bus = sum[DATA_W-1:0];
      SRC_A:    bus = a_q;
      SRC_RAM:  bus = ram_rdata;
      SRC_IR:   bus = {{(DATA_W-ADDR_W){1'b0}}, ir_q[ADDR_W-1:0]};
      SRC_PC:   bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
      default:  bus = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      ir_q   <= '0;
      mar_q  <= '0;
      out_q  <= '0;
      pc_q   <= '0;
      cf     <= 1'b0;
      zf     <= 1'b0;
      halted <= 1'b0;
    end else begin
      if (!prog_mode && ctrl.hlt) halted <= 1'b1;
      if (active) begin
        if (ctrl.mi) mar_q <= bus[ADDR_W-1:0];
        if (ctrl.ii) ir_q  <= bus;
        if (ctrl.ai) a_q   <= bus;
        if (ctrl.bi) b_q   <= bus;
        if (ctrl.oi) out_q <= bus;
        if (ctrl.j)       pc_q <= bus[ADDR_W-1:0];
        else if (ctrl.ce) pc_q <= pc_q + ADDR_W'(1);
        if (ctrl.sumo) begin
          cf <= sum[DATA_W];
          zf <= (sum[DATA_W-1:0] == '0);
        end
      end
    end
  end

  sap_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .prog_mode (prog_mode),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .dp_we     (active && ctrl.ri),
    .dp_addr   (mar_q),
    .dp_data   (bus),
    .raddr     (mar_q),
    .rdata     (ram_rdata)
  );

  assign insn    = ir_q;
  assign out_val = out_q;
  assign pc_dbg  = pc_q;
  assign bus_dbg = bus;

endmodule

// File: tb/tb_sap_datapath.sv
// tb_sap_datapath: directed bench for sap_datapath. Controls change on negedge,
// the DUT acts on posedge, and outputs are sampled at the following negedge.
module tb_sap_datapath;

  localparam logic [14:0] HLT  = 15'h4000;
  localparam logic [14:0] MI   = 15'h2000;
  localparam logic [14:0] RI   = 15'h1000;
  localparam logic [14:0] RO   = 15'h0800;
  localparam logic [14:0] IO   = 15'h0400;
  localparam logic [14:0] II   = 15'h0200;
  localparam logic [14:0] AI   = 15'h0100;
  localparam logic [14:0] AO   = 15'h0080;
  localparam logic [14:0] SUMO = 15'h0040;
  localparam logic [14:0] SUB  = 15'h0020;
  localparam logic [14:0] BI   = 15'h0010;
  localparam logic [14:0] OI   = 15'h0008;
  localparam logic [14:0] CE   = 15'h0004;
  localparam logic [14:0] CO   = 15'h0002;
  localparam logic [14:0] J    = 15'h0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_mode, prog_we;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [14:0] ctl;
  logic [7:0]  insn, out_val, bus_dbg;
  logic        cf, zf, halted;
  logic [3:0]  pc_dbg;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  sap_datapath dut (
    .clk       (clk),
    .rst       (rst),
    .prog_mode (prog_mode),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .hlt       (ctl[14]),
    .mi        (ctl[13]),
    .ri        (ctl[12]),
    .ro        (ctl[11]),
    .io        (ctl[10]),
    .ii        (ctl[9]),
    .ai        (ctl[8]),
    .ao        (ctl[7]),
    .sumo      (ctl[6]),
    .sub       (ctl[5]),
    .bi        (ctl[4]),
    .oi        (ctl[3]),
    .ce        (ctl[2]),
    .co        (ctl[1]),
    .j         (ctl[0]),
    .insn      (insn),
    .cf        (cf),
    .zf        (zf),
    .out_val   (out_val),
    .pc_dbg    (pc_dbg),
    .bus_dbg   (bus_dbg),
    .halted    (halted)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One control cycle: drive at negedge, let the posedge act, idle at next negedge.
  task automatic step(input logic [14:0] c);
    @(negedge clk);
    ctl = c;
    @(negedge clk);
    ctl = '0;
  endtask

  // Look at the combinational bus for a control set without letting it clock.
  task automatic peek(input logic [14:0] c, input string tag, input logic [7:0] exp);
    @(negedge clk);
    ctl = c;
    #1;
    check(tag, bus_dbg, exp);
    ctl = '0;
  endtask

  task automatic prog_write(input logic [3:0] addr, input logic [7:0] data);
    @(negedge clk);
    prog_mode = 1'b1;
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    @(posedge clk);
    #1;
    prog_we = 1'b0;
  endtask

  task automatic set_pc(input logic [3:0] target);
    for (int i = 0; i < 17; i++) begin
      if (pc_dbg === target) break;
      step(CE);
    end
    check("set_pc", 8'(pc_dbg), 8'(target));
  endtask

  task automatic load_from_ram(input logic [3:0] addr, input logic [14:0] sel);
    set_pc(addr);
    step(MI | CO);
    step(RO | sel);
  endtask

  initial begin
    rst = 1'b0; prog_mode = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_data = '0; ctl = '0;
    #1;
    check("rst_insn",   insn,        8'h00);
    check("rst_out",    out_val,     8'h00);
    check("rst_pc",     8'(pc_dbg),  8'h00);
    check("rst_cf",     8'(cf),      8'h00);
    check("rst_zf",     8'(zf),      8'h00);
    check("rst_halted", 8'(halted),  8'h00);
    #11 rst = 1'b1;

    // Program image.
    prog_write(4'd0,  8'h1E);
    prog_write(4'd1,  8'h33);
    prog_write(4'd2,  8'hF0);
    prog_write(4'd3,  8'h5A);
    prog_write(4'd4,  8'h20);
    prog_write(4'd6,  8'h05);
    prog_write(4'd8,  8'h6B);
    prog_write(4'd9,  8'h77);
    prog_write(4'd14, 8'h1C);
    @(negedge clk);
    prog_mode = 1'b0;

    // LDA 14 fetch/execute.
    step(MI | CO);
    step(RO | II | CE);
    step(MI | IO);
    step(RO | AI);
    check("lda_ir", insn, 8'h1E);
    check("lda_pc", 8'(pc_dbg), 8'h01);
    peek(RO, "lda_mar_ram", 8'h1C);
    peek(AO, "lda_a", 8'h1C);

    // ADD overflow, then flags hold through a non-sumo cycle.
    load_from_ram(4'd2, AI);
    load_from_ram(4'd4, BI);
    step(SUMO | AI);
    peek(AO, "add_a", 8'h10);
    check("add_cf", 8'(cf), 8'h01);
    check("add_zf", 8'(zf), 8'h00);
    step(AO | OI);
    check("add_out", out_val, 8'h10);
    check("hold_cf", 8'(cf), 8'h01);
    check("hold_zf", 8'(zf), 8'h00);

    // SUB equal, then SUB with borrow.
    load_from_ram(4'd6, AI);
    load_from_ram(4'd6, BI);
    step(SUMO | SUB | AI);
    peek(AO, "sub_eq_a", 8'h00);
    check("sub_eq_cf", 8'(cf), 8'h01);
    check("sub_eq_zf", 8'(zf), 8'h01);
    step(SUMO | SUB | AI);
    peek(AO, "sub_lt_a", 8'hFB);
    check("sub_lt_cf", 8'(cf), 8'h00);
    check("sub_lt_zf", 8'(zf), 8'h00);

    // PC wrap, jump priority, bus priority.
    set_pc(4'd15);
    step(CE);
    check("pc_wrap", 8'(pc_dbg), 8'h00);
    load_from_ram(4'd8, II);
    check("ir_6b", insn, 8'h6B);
    step(J | CE | IO);
    check("jump_pc", 8'(pc_dbg), 8'h0B);
    load_from_ram(4'd9, AI);
    peek(AO | CO,   "bus_ao_over_co",   8'h77);
    peek(SUMO | AO, "bus_sum_over_ao",  8'h7C);
    peek(RO | IO,   "bus_ro_over_io",   8'h77);
    peek(IO | CO,   "bus_io_over_co",   8'h0B);
    peek('0,        "bus_idle",         8'h00);

    // Program-mode isolation.
    @(negedge clk);
    prog_mode = 1'b1; prog_we = 1'b1; prog_addr = 4'd5; prog_data = 8'hAA;
    ctl = AI | CE | AO;
    #1;
    check("prog_bus", bus_dbg, 8'h00);
    @(negedge clk);
    prog_mode = 1'b0; prog_we = 1'b0; ctl = '0;
    check("prog_pc_hold", 8'(pc_dbg), 8'h09);
    peek(AO, "prog_a_hold", 8'h77);
    set_pc(4'd5);
    step(MI | CO);
    peek(RO, "prog_ram5", 8'hAA);

    // Halt: the hlt cycle itself and all later cycles are inert.
    step(HLT | SUMO | AI | CE);
    check("halt_set", 8'(halted), 8'h01);
    check("halt_pc", 8'(pc_dbg), 8'h05);
    peek(AO, "halt_a", 8'h77);
    step(CE);
    step(RO | II);
    step(AO | OI);
    step(J | IO);
    check("halted_pc",   8'(pc_dbg), 8'h05);
    check("halted_ir",   insn, 8'h6B);
    check("halted_out",  out_val, 8'h10);
    check("halted_stay", 8'(halted), 8'h01);

    // Reset clears halt.
    @(negedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst1_halted", 8'(halted), 8'h00);
    check("rst1_pc",     8'(pc_dbg), 8'h00);
    check("rst1_ir",     insn, 8'h00);
    check("rst1_out",    out_val, 8'h00);
    @(negedge clk);
    #2 rst = 1'b1;

    // Build up state, then reset mid-run.
    load_from_ram(4'd1, AI);
    step(AO | OI);
    load_from_ram(4'd8, II);
    step(SUMO | SUB);
    check("pre_cf", 8'(cf), 8'h01);
    check("pre_out", out_val, 8'h33);
    set_pc(4'd7);
    @(negedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst2_pc",  8'(pc_dbg), 8'h00);
    check("rst2_out", out_val, 8'h00);
    check("rst2_ir",  insn, 8'h00);
    check("rst2_cf",  8'(cf), 8'h00);
    ctl = AO;
    #1;
    check("rst2_a", bus_dbg, 8'h00);
    ctl = '0;
    @(negedge clk);
    #2 rst = 1'b1;
    set_pc(4'd3);
    step(MI | CO);
    peek(RO, "ram3_retained", 8'h5A);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sap_datapath.md
# sap_datapath

Register/bus datapath of the 8-bit SAP CPU, directly downstream of the microcode decoder. Consumes the decoder's one-hot control lines each cycle: drives the shared 8-bit bus and loads A, B, IR, MAR, PC, OUT and a 16x8 RAM. Feeds `insn`, `cf` and `zf` back to the decoder. Also hosts the program-load port used while `prog_mode` is high.

## Interface
- `DATA_W`, 8, bus/register width
- `ADDR_W`, 4, RAM/PC/MAR address width (RAM depth 2^ADDR_W)
- `clk`  in  1  system clock. Datapath acts on posedge; the decoder updates controls on negedge.
- `rst`  in  1  asynchronous, active-low reset
- `prog_mode`  in  1  program-load mode
- `prog_we`  in  1  program write strobe
- `prog_addr`  in  ADDR_W  program write address
- `prog_data`  in  DATA_W  program write data
- `hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j`  in  1 each  decoder control lines
- `insn`  out  DATA_W  instruction register
- `cf`, `zf`  out  1  carry / zero flags
- `out_val`  out  DATA_W  output register
- `pc_dbg`  out  ADDR_W  program counter
- `bus_dbg`  out  DATA_W  current bus value
- `halted`  out  1  sticky halt indicator

## Operation
- Bus driver is combinational. Priority order: `sumo` > `ao` > `ro` > `io` > `co`. If no driver is active, the bus is 8'h00.
- Bus sources:
  - `sumo`: ALU result[7:0]
  - `ao`: A
  - `ro`: RAM[MAR], asynchronous read
  - `io`: {4'h0, IR[3:0]}
  - `co`: {4'h0, PC}
- ALU:
  - 9-bit sum = A + (sub ? ~B : B) + sub
  - `cf_next` = sum[8]
  - `zf_next` = (sum[7:0] == 0)
- Posedge loads, all in parallel from the same bus value:
  - `mi`: MAR <= bus[3:0]
  - `ri`: RAM[MAR] <= bus
  - `ii`: IR <= bus
  - `ai`: A <= bus
  - `bi`: B <= bus
  - `oi`: OUT <= bus
- PC: `j` loads PC <= bus[3:0]. Otherwise `ce` increments PC, modulo 16 (15 wraps to 0). `j` beats `ce`.
- Flags load `cf_next`/`zf_next` on posedge only when `sumo` is high; otherwise they hold.
- `hlt` high at a posedge:
  - `halted` <= 1.
  - All register, flag, PC and RAM updates in that cycle are suppressed.
  - `halted` clears only on reset.
  - While `halted`=1, all loads are suppressed regardless of controls.
- `prog_mode` high:
  - All control inputs are ignored and registers hold.
  - If `prog_we`, RAM[prog_addr] <= prog_data on posedge.
  - `bus_dbg` reads 8'h00.
- `ri` with `ro` in the same cycle rewrites the same data, so RAM is unchanged.

## Timing
- Reset (async assert):
  - A, B, IR, MAR, OUT, PC, `cf`, `zf`, `halted` = 0 immediately.
  - RAM contents are retained (not reset).
  - Reset release takes effect at the first posedge after `rst` rises.
- Reset mid-instruction discards all partial state; the decoder restarts fetch.
- Load latency is 1 edge: the control is valid from negedge and the register updates at the following posedge. Outputs are registered except `bus_dbg`.
- The RAM read path is combinational from MAR, so `mi` at cycle N allows `ro` at cycle N+1.
- `halted` rises at the posedge where `hlt` is sampled high.

## Structure
- Package `sap_pkg`:
  - `DATA_W`/`ADDR_W` constants
  - `bus_src_t` enum (NONE, SUM, A, RAM, IR, PC)
  - control-word packed struct matching the decoder's 15-bit order {hlt…j}
- Sub-module `sap_ram`: 16x8 array, async read, sync write, with write-port mux between the datapath and the program port.
- Top level holds the bus priority mux, ALU, registers and PC.

## Test plan
- Reset check: drive `rst`=0 mid-run with A=0x33 and PC=7 → all outputs 0 at once. RAM[3] preloaded with 0x5A still reads 0x5A after reset.
- LDA 14 fetch/execute: prog mode writes RAM[0]=0x1E and RAM[14]=0x1C. Sequence: {mi,co}, {ro,ii,ce}, {mi,io}, {ro,ai} → IR=0x1E, PC=1, MAR=14, A=0x1C.
- ADD overflow: A=0xF0, B=0x20, {sumo,ai} → A=0x10, `cf`=1, `zf`=0. Then an {ao,oi} cycle → `out_val`=0x10 and flags unchanged.
- SUB equal: A=0x05, B=0x05, {sumo,sub,ai} → A=0x00, `cf`=1, `zf`=1.
- PC rules:
  - PC=15, `ce` → PC=0.
  - `j`+`ce`+`io` with IR=0x6B → PC=0xB.
  - Bus conflict `ao`+`co` with A=0x77 → `bus_dbg`=0x77.
- Halt and prog isolation:
  - `hlt` together with `ai`/`ao` → A unchanged, `halted`=1; later controls have no effect.
  - With `prog_mode`=1 and `ai`,`ce` asserted → A and PC hold, while `prog_we` writes RAM[5]=0xAA.
